// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU control codes and execute-stage buffer states.
package cpu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_e;

    function automatic logic alu_ctrl_legal(input logic [2:0] ctrl);
        return (ctrl == ALU_AND) || (ctrl == ALU_OR) || (ctrl == ALU_ADD) ||
               (ctrl == ALU_SUB) || (ctrl == ALU_SLT);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: (control, a, b) -> result, zero, illegal, ovf.
// ovf is always computed here; the stage only uses it when EX_ALU_OVF_EN is defined.
module alu_core
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       ctrl_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             illegal_o,
    output logic             ovf_o
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             lt;

    assign sum  = a_i + b_i;
    assign diff = a_i - b_i;
    assign lt   = $signed(a_i) < $signed(b_i);

    always_comb begin
        result_o  = '0;
        illegal_o = 1'b0;
        ovf_o     = 1'b0;
        case (ctrl_i)
            ALU_ADD: begin
                result_o = sum;
                ovf_o    = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
            end
            ALU_SUB: begin
                result_o = diff;
                ovf_o    = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
            end
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_SLT: result_o = {{(WIDTH-1){1'b0}}, lt};
            default: illegal_o = 1'b1;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/ex_alu_stage.sv
// Execute stage: ALU on the input side, two-entry (output + skid) buffer toward MEM.
// Optional signed-overflow output and writeback suppression under EX_ALU_OVF_EN.
module ex_alu_stage
    import cpu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         alu_control,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    input  logic [RADDR_W-1:0] in_dest,
    input  logic               in_reg_write,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               illegal,
    output logic [RADDR_W-1:0] out_dest,
    output logic               out_reg_write
`ifdef EX_ALU_OVF_EN
    ,
    output logic               ovf
`endif
);

    logic [WIDTH-1:0] alu_res;
    logic             alu_zero;
    logic             alu_ill;
    logic             alu_ovf;
    logic             new_rw;
    logic             new_ovf;
    logic             accept;

    alu_core #(.WIDTH(WIDTH)) u_alu (
        .ctrl_i    (alu_control),
        .a_i       (op_a),
        .b_i       (op_b),
        .result_o  (alu_res),
        .zero_o    (alu_zero),
        .illegal_o (alu_ill),
        .ovf_o     (alu_ovf)
    );

`ifdef EX_ALU_OVF_EN
    assign new_ovf = alu_ovf;
`else
    assign new_ovf = 1'b0;
    logic unused_ovf;
    assign unused_ovf = alu_ovf;
`endif
    assign new_rw = in_reg_write && !alu_ill && !new_ovf;

    stage_state_e     state_q;
    logic             in_ready_q, out_valid_q;
    logic [WIDTH-1:0] res_q, sk_res_q;
    logic             zero_q, sk_zero_q;
    logic             ill_q, sk_ill_q;
    logic [RADDR_W-1:0] dest_q, sk_dest_q;
    logic             rw_q, sk_rw_q;
    logic             ovf_q, sk_ovf_q;

    // in_ready_q is only ever high outside FULL, so it doubles as the state gate.
    assign accept = in_valid && in_ready_q && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            zero_q      <= 1'b0;
            ill_q       <= 1'b0;
            dest_q      <= '0;
            rw_q        <= 1'b0;
            ovf_q       <= 1'b0;
            sk_res_q    <= '0;
            sk_zero_q   <= 1'b0;
            sk_ill_q    <= 1'b0;
            sk_dest_q   <= '0;
            sk_rw_q     <= 1'b0;
            sk_ovf_q    <= 1'b0;
        end else if (flush) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        res_q       <= alu_res;
                        zero_q      <= alu_zero;
                        ill_q       <= alu_ill;
                        dest_q      <= in_dest;
                        rw_q        <= new_rw;
                        ovf_q       <= new_ovf;
                        state_q     <= ST_ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && out_ready) begin
                        res_q  <= alu_res;
                        zero_q <= alu_zero;
                        ill_q  <= alu_ill;
                        dest_q <= in_dest;
                        rw_q   <= new_rw;
                        ovf_q  <= new_ovf;
                    end else if (accept) begin
                        sk_res_q   <= alu_res;
                        sk_zero_q  <= alu_zero;
                        sk_ill_q   <= alu_ill;
                        sk_dest_q  <= in_dest;
                        sk_rw_q    <= new_rw;
                        sk_ovf_q   <= new_ovf;
                        state_q    <= ST_FULL;
                        in_ready_q <= 1'b0;
                    end else if (out_ready) begin
                        state_q     <= ST_EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        res_q      <= sk_res_q;
                        zero_q     <= sk_zero_q;
                        ill_q      <= sk_ill_q;
                        dest_q     <= sk_dest_q;
                        rw_q       <= sk_rw_q;
                        ovf_q      <= sk_ovf_q;
                        state_q    <= ST_ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign result        = res_q;
    assign zero          = zero_q;
    assign illegal       = ill_q;
    assign out_dest      = dest_q;
    assign out_reg_write = rw_q;
`ifdef EX_ALU_OVF_EN
    assign ovf = ovf_q;
`else
    logic unused_ovf_q;
    assign unused_ovf_q = ovf_q ^ sk_ovf_q;
`endif

endmodule

// File: tb/tb_ex_alu_stage.sv
// Directed bench for ex_alu_stage: ALU ops, skid buffering, flush, async reset.
module tb_ex_alu_stage;

    localparam int W  = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [2:0]    alu_control;
    logic [W-1:0]  op_a, op_b, result;
    logic [RW-1:0] in_dest, out_dest;
    logic          in_reg_write, zero, illegal, out_reg_write;
`ifdef EX_ALU_OVF_EN
    logic          ovf;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    ex_alu_stage #(.WIDTH(W), .RADDR_W(RW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_control(alu_control), .op_a(op_a), .op_b(op_b),
        .in_dest(in_dest), .in_reg_write(in_reg_write),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .illegal(illegal),
        .out_dest(out_dest), .out_reg_write(out_reg_write)
`ifdef EX_ALU_OVF_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] c, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [RW-1:0] d, input logic rw);
        in_valid = v; alu_control = c; op_a = a; op_b = b; in_dest = d; in_reg_write = rw;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 3'b000, '0, '0, '0, 1'b0);
        #12;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_result", result, 0);
        chk("rst_flags", {27'd0, zero, illegal, out_reg_write, 2'b00}, 0);
        chk("rst_dest", 32'(out_dest), 0);
        rst_n = 1'b1;
        tick();

        drive(1'b1, 3'b010, 5, 7, 5'd3, 1'b1);
        tick();
        chk("add_valid", 32'(out_valid), 1);
        chk("add_result", result, 12);
        chk("add_zero", 32'(zero), 0);
        chk("add_ready", 32'(in_ready), 1);
        chk("add_dest", 32'(out_dest), 3);
        chk("add_rw", 32'(out_reg_write), 1);

        drive(1'b1, 3'b110, 3, 3, 5'd4, 1'b1);
        tick();
        chk("sub_result", result, 0);
        chk("sub_zero", 32'(zero), 1);

        drive(1'b1, 3'b111, 32'hFFFF_FFFF, 1, 5'd5, 1'b1);
        tick();
        chk("slt_result", result, 1);
        chk("slt_zero", 32'(zero), 0);

        drive(1'b1, 3'b000, 32'hF0F0_1234, 32'h0FF0_00FF, 5'd6, 1'b1);
        tick();
        chk("and_result", result, 32'h00F0_0034);

        drive(1'b1, 3'b011, 32'h1234, 32'h5678, 5'd7, 1'b1);
        tick();
        chk("ill_flag", 32'(illegal), 1);
        chk("ill_result", result, 0);
        chk("ill_rw", 32'(out_reg_write), 0);

        drive(1'b0, 3'b000, '0, '0, '0, 1'b0);
        tick();
        chk("drain_valid", 32'(out_valid), 0);

        // Skid fill: two accepts while MEM stalls.
        out_ready = 1'b0;
        drive(1'b1, 3'b010, 1, 1, 5'd8, 1'b1);
        tick();
        chk("one_result", result, 2);
        chk("one_ready", 32'(in_ready), 1);
        drive(1'b1, 3'b001, 32'hF0, 32'h0F, 5'd9, 1'b1);
        tick();
        chk("full_ready", 32'(in_ready), 0);
        chk("full_hold", result, 2);
        drive(1'b1, 3'b010, 32'h100, 32'h100, 5'd10, 1'b1);
        tick();
        chk("full_hold2", result, 2);
        chk("full_dest", 32'(out_dest), 8);
        drive(1'b0, 3'b000, '0, '0, '0, 1'b0);
        out_ready = 1'b1;
        tick();
        chk("skid_result", result, 32'hFF);
        chk("skid_dest", 32'(out_dest), 9);
        chk("skid_ready", 32'(in_ready), 1);
        tick();
        chk("skid_drain", 32'(out_valid), 0);

        // Flush from FULL with a same-cycle input.
        out_ready = 1'b0;
        drive(1'b1, 3'b010, 32'h10, 0, 5'd1, 1'b1);
        tick();
        drive(1'b1, 3'b010, 32'h20, 0, 5'd2, 1'b1);
        tick();
        chk("fl_full", 32'(in_ready), 0);
        flush = 1'b1;
        drive(1'b1, 3'b010, 32'h55, 0, 5'd3, 1'b1);
        tick();
        chk("fl_valid", 32'(out_valid), 0);
        chk("fl_ready", 32'(in_ready), 1);
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 3'b000, '0, '0, '0, 1'b0);
        tick();
        chk("fl_gone", 32'(out_valid), 0);

        // Throughput: one result per cycle with MEM always ready.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'b010, 32'(i * 100), 32'd7, 5'(i), 1'b1);
            tick();
            chk("tput_result", result, 32'(i * 100 + 7));
            chk("tput_ready", 32'(in_ready), 1);
        end

        drive(1'b1, 3'b010, 32'h7FFF_FFFF, 1, 5'd11, 1'b1);
        tick();
        chk("ovf_add_result", result, 32'h8000_0000);
`ifdef EX_ALU_OVF_EN
        chk("ovf_add_flag", 32'(ovf), 1);
        chk("ovf_add_rw", 32'(out_reg_write), 0);
        drive(1'b1, 3'b110, 32'h8000_0000, 1, 5'd12, 1'b1);
        tick();
        chk("ovf_sub_result", result, 32'h7FFF_FFFF);
        chk("ovf_sub_flag", 32'(ovf), 1);
        drive(1'b1, 3'b010, 2, 3, 5'd13, 1'b1);
        tick();
        chk("noovf_flag", 32'(ovf), 0);
        chk("noovf_rw", 32'(out_reg_write), 1);
`else
        chk("ovf_add_rw", 32'(out_reg_write), 1);
`endif

        // Asynchronous reset while FULL.
        out_ready = 1'b0;
        drive(1'b1, 3'b010, 32'h30, 0, 5'd1, 1'b1);
        tick();
        drive(1'b1, 3'b010, 32'h40, 0, 5'd2, 1'b1);
        tick();
        chk("ar_full", 32'(in_ready), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 0);
        chk("ar_ready", 32'(in_ready), 1);
        chk("ar_result", result, 0);
        drive(1'b0, 3'b000, '0, '0, '0, 1'b0);
        out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        chk("ar_after", 32'(out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_alu_stage.md
# ex_alu_stage

Execute stage of the pipelined CPU, directly downstream of `alu_control`. It takes the 3-bit ALU control code plus the operands and destination info forwarded from ID/EX, and computes the ALU result. It registers the result, zero flag and writeback info into a two-entry output buffer (output register plus skid) with a valid/ready handshake toward the MEM stage. The ready signal toward ID/EX is therefore driven from a register, which keeps the stall path short.

## Interface
- `WIDTH`, 32, datapath width of operands and result
- `RADDR_W`, 5, register-file address width

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `flush`  in  1  synchronous squash of all buffered and incoming entries
- `in_valid`  in  1  ID/EX presents an operation
- `in_ready`  out  1  stage can accept; registered
- `alu_control`  in  3  operation code from `alu_control`
- `op_a`, `op_b`  in  WIDTH  operands
- `in_dest`  in  RADDR_W  destination register
- `in_reg_write`  in  1  writeback enable
- `out_valid`  out  1  result entry present toward MEM
- `out_ready`  in  1  MEM accepts the entry
- `result`  out  WIDTH  ALU result
- `zero`  out  1  result == 0
- `illegal`  out  1  `alu_control` was not a defined code
- `out_dest`  out  RADDR_W  forwarded destination
- `out_reg_write`  out  1  forwarded writeback enable
- `ovf`  out  1  signed overflow; present only with `EX_ALU_OVF_EN`

## Operation
- ALU control codes:
  - 010: add (wrap mod 2^WIDTH)
  - 110: sub (a − b, wrap)
  - 000: and
  - 001: or
  - 111: slt, signed compare; result {WIDTH-1 zeros, a<b}
- Any other code: result = 0, illegal = 1, out_reg_write forced 0.
- The ALU is evaluated combinationally on the input side. A computed entry is {result, zero, illegal, dest, reg_write[, ovf]}.
- Accept condition: `in_valid && in_ready && !flush`.
- States:
  - EMPTY: out_valid=0, in_ready=1
  - ONE: out_valid=1, in_ready=1
  - FULL: out_valid=1, in_ready=0; the skid entry is occupied
- Transitions:
  - EMPTY: accept → ONE (entry loads into the output register).
  - ONE:
    - accept && out_ready → ONE (output register replaced).
    - accept && !out_ready → FULL (entry loads into skid).
    - !accept && out_ready → EMPTY.
  - FULL: out_ready → ONE (skid moves to output register). No input is accepted in FULL.
- flush: next state is EMPTY and both entries are invalidated. A same-cycle input is dropped. flush overrides out_ready.
- While out_valid && !out_ready, all output fields hold stable.
- Reset values: state EMPTY, out_valid 0, in_ready 1, and result, zero, illegal, out_dest, out_reg_write, ovf all 0.

## Timing
- Latency: accept in cycle N → out_valid with data in cycle N+1 (from EMPTY or ONE with out_ready).
- Throughput: one entry per cycle while out_ready is held high.
- in_ready deasserts the cycle after entering FULL. It reasserts the cycle after out_ready is seen in FULL.
- Reset may assert mid-transfer. Everything clears immediately (asynchronously), and in-flight entries are lost.
- A buffered skid entry is delivered only after the output-register entry; order is always preserved.

## Configuration
- `EX_ALU_OVF_EN` defined:
  - `ovf` port exists. It is set for add when the operand signs match and the result sign differs. It is set for sub when the operand signs differ and the result sign differs from a.
  - When ovf=1, out_reg_write is forced 0 (writeback suppressed).
- Not defined: the `ovf` port and logic are absent, and out_reg_write is in_reg_write gated only by illegal.

## Structure
- Shared package `cpu_pkg`:
  - ALU control code constants: ALU_AND 000, ALU_OR 001, ALU_ADD 010, ALU_SUB 110, ALU_SLT 111.
  - Stage state encoding: EMPTY, ONE, FULL.
  - The `alu_control` block uses the same constants.
- Sub-module `alu_core`: purely combinational, WIDTH-parameterised. Maps (control, a, b) → result, zero, illegal[, ovf]. It is instantiated once on the input side.

## Test plan
- Reset, then in_valid=1, control=010, a=5, b=7, out_ready=1 → next cycle out_valid=1, result=12, zero=0; in_ready stays 1.
- control=110, a=3, b=3 → result=0, zero=1. Then control=111, a=0xFFFFFFFF, b=1 → result=1 (signed −1<1).
- out_ready=0 with two back-to-back accepts (add 1+1, then or 0xF0|0x0F) → FULL, in_ready=0 the following cycle, output holds 2. Then out_ready=1 → delivers 2 then 0xFF in order.
- State FULL, flush=1 with in_valid=1 → next cycle out_valid=0, in_ready=1, EMPTY; the flushed input never appears.
- control=011, in_reg_write=1 → illegal=1, result=0, out_reg_write=0.
- With `EX_ALU_OVF_EN`: add 0x7FFFFFFF+1 → ovf=1, result 0x80000000, out_reg_write=0. Assert rst_n low mid-FULL → out_valid 0 immediately.
